// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS decode/execute slice: opcode and funct
// constants, ALU control encodings, forwarding selects, the packed control
// bundle carried down the pipeline, and a sign-extension helper.
package mips_pkg;

  // Main-decode opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_NOR = 6'h27;

  // ALU control encodings
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // aluop classes produced by the main decoder
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  // Forwarding selects; any other value means "use the register operand"
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch_eq;
    logic       branch_ne;
    logic       jump;
    logic [1:0] aluop;
  } ctrl_t;

  // All-zero control: a pipeline bubble
  localparam ctrl_t CTRL_NOP = ctrl_t'(11'b0);

  function automatic logic [31:0] sign_extend(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_alu.sv
// mips_alu
// Combinational 32-bit ALU with zero flag.
// Ports: a, b (32-bit operands), ctl (4-bit operation select),
//        result (32-bit), zero (result == 0).
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ctl,
  output logic [31:0] result,
  output logic        zero
);

  // Operation select; unknown encodings yield 0
  always_comb begin
    result = 32'h0000_0000;
    case (ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_NOR: result = ~(a | b);
      default: result = 32'h0000_0000;
    endcase
  end

  assign zero = (result == 32'h0000_0000);

endmodule

// File: rtl/mips_decode_execute.sv
// mips_decode_execute
// ID/EX/MEM slice of a five-stage MIPS pipeline. Decodes the ID instruction,
// registers control and operands into ID/EX, executes with forwarded
// operands in EX and registers the result and control into EX/MEM.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   instr_d, rdata1_d/2_d instruction and register-file data in ID
//   stall, flush          bubble ID/EX; kill ID/EX and EX/MEM control
//   fwd_a/b, fwd_mem/wb   forwarding selects and forwarded values
//   rs_e, rt_e, memread_e EX-stage fields for hazard/forwarding units
//   *_m                   EX/MEM outputs; pcsrc_m is the branch decision
module mips_decode_execute
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_d,
  input  logic [31:0] rdata1_d,
  input  logic [31:0] rdata2_d,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] fwd_mem,
  input  logic [31:0] fwd_wb,
  output logic [4:0]  rs_e,
  output logic [4:0]  rt_e,
  output logic        memread_e,
  output logic [31:0] alu_result_m,
  output logic        zero_m,
  output logic [31:0] store_data_m,
  output logic [4:0]  wrreg_m,
  output logic        regwrite_m,
  output logic        memtoreg_m,
  output logic        memread_m,
  output logic        memwrite_m,
  output logic        jump_m,
  output logic        pcsrc_m
);

  ctrl_t       ctrl_d_s;
  ctrl_t       ctrl_e_r;
  logic [31:0] rdata1_e_r;
  logic [31:0] rdata2_e_r;
  logic [31:0] seimm_e_r;
  logic [4:0]  rd_e_r;
  logic [3:0]  alu_ctl_s;
  logic [31:0] op_a_s;
  logic [31:0] rt_fwd_s;
  logic [31:0] op_b_s;
  logic [4:0]  wrreg_e_s;
  logic [31:0] alu_out_s;
  logic        alu_zero_s;
  logic        branch_eq_m_r;
  logic        branch_ne_m_r;

  function automatic logic [31:0] fwd_sel(input logic [1:0]  sel,
                                          input logic [31:0] reg_val,
                                          input logic [31:0] mem_val,
                                          input logic [31:0] wb_val);
    case (sel)
      FWD_MEM: return mem_val;
      FWD_WB:  return wb_val;
      default: return reg_val;
    endcase
  endfunction

  // Main decode: unlisted opcodes fall through to an all-zero NOP
  always_comb begin
    ctrl_d_s = CTRL_NOP;
    case (instr_d[31:26])
      OP_RTYPE: begin
        ctrl_d_s.regdst   = 1'b1;
        ctrl_d_s.regwrite = 1'b1;
        ctrl_d_s.aluop    = ALUOP_FN;
      end
      OP_LW: begin
        ctrl_d_s.memread  = 1'b1;
        ctrl_d_s.memtoreg = 1'b1;
        ctrl_d_s.alusrc   = 1'b1;
        ctrl_d_s.regwrite = 1'b1;
      end
      OP_SW: begin
        ctrl_d_s.memwrite = 1'b1;
        ctrl_d_s.alusrc   = 1'b1;
      end
      OP_BEQ: begin
        ctrl_d_s.branch_eq = 1'b1;
        ctrl_d_s.aluop     = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl_d_s.branch_ne = 1'b1;
        ctrl_d_s.aluop     = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl_d_s.alusrc   = 1'b1;
        ctrl_d_s.regwrite = 1'b1;
      end
      OP_J:    ctrl_d_s.jump = 1'b1;
      default: ctrl_d_s = CTRL_NOP;
    endcase
  end

  // ID/EX register: a stall or flush zeroes control only; data always loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_e_r   <= CTRL_NOP;
      rdata1_e_r <= 32'h0000_0000;
      rdata2_e_r <= 32'h0000_0000;
      seimm_e_r  <= 32'h0000_0000;
      rs_e       <= 5'd0;
      rt_e       <= 5'd0;
      rd_e_r     <= 5'd0;
    end else begin
      ctrl_e_r   <= (stall || flush) ? CTRL_NOP : ctrl_d_s;
      rdata1_e_r <= rdata1_d;
      rdata2_e_r <= rdata2_d;
      seimm_e_r  <= sign_extend(instr_d[15:0]);
      rs_e       <= instr_d[25:21];
      rt_e       <= instr_d[20:16];
      rd_e_r     <= instr_d[15:11];
    end
  end

  assign memread_e = ctrl_e_r.memread;

  // ALU control; the funct field is the low six bits of the immediate
  always_comb begin
    alu_ctl_s = ALU_ADD;
    case (ctrl_e_r.aluop)
      ALUOP_ADD: alu_ctl_s = ALU_ADD;
      ALUOP_SUB: alu_ctl_s = ALU_SUB;
      ALUOP_FN: begin
        case (seimm_e_r[5:0])
          FN_ADD:  alu_ctl_s = ALU_ADD;
          FN_SUB:  alu_ctl_s = ALU_SUB;
          FN_AND:  alu_ctl_s = ALU_AND;
          FN_OR:   alu_ctl_s = ALU_OR;
          FN_SLT:  alu_ctl_s = ALU_SLT;
          FN_NOR:  alu_ctl_s = ALU_NOR;
          default: alu_ctl_s = ALU_ADD;
        endcase
      end
      default: alu_ctl_s = ALU_ADD;
    endcase
  end

  assign op_a_s    = fwd_sel(fwd_a, rdata1_e_r, fwd_mem, fwd_wb);
  assign rt_fwd_s  = fwd_sel(fwd_b, rdata2_e_r, fwd_mem, fwd_wb);
  assign op_b_s    = ctrl_e_r.alusrc ? seimm_e_r : rt_fwd_s;
  assign wrreg_e_s = ctrl_e_r.regdst ? rd_e_r : rt_e;

  mips_alu u_alu (
    .a      (op_a_s),
    .b      (op_b_s),
    .ctl    (alu_ctl_s),
    .result (alu_out_s),
    .zero   (alu_zero_s)
  );

  // EX/MEM register: flush kills the EX instruction's control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_m  <= 32'h0000_0000;
      zero_m        <= 1'b0;
      store_data_m  <= 32'h0000_0000;
      wrreg_m       <= 5'd0;
      regwrite_m    <= 1'b0;
      memtoreg_m    <= 1'b0;
      memread_m     <= 1'b0;
      memwrite_m    <= 1'b0;
      jump_m        <= 1'b0;
      branch_eq_m_r <= 1'b0;
      branch_ne_m_r <= 1'b0;
    end else begin
      alu_result_m  <= alu_out_s;
      zero_m        <= alu_zero_s;
      store_data_m  <= rt_fwd_s;
      wrreg_m       <= wrreg_e_s;
      regwrite_m    <= ctrl_e_r.regwrite  & ~flush;
      memtoreg_m    <= ctrl_e_r.memtoreg  & ~flush;
      memread_m     <= ctrl_e_r.memread   & ~flush;
      memwrite_m    <= ctrl_e_r.memwrite  & ~flush;
      jump_m        <= ctrl_e_r.jump      & ~flush;
      branch_eq_m_r <= ctrl_e_r.branch_eq & ~flush;
      branch_ne_m_r <= ctrl_e_r.branch_ne & ~flush;
    end
  end

  assign pcsrc_m = (branch_eq_m_r & zero_m) | (branch_ne_m_r & ~zero_m);

endmodule

// File: tb/tb_mips_decode_execute.sv
// tb_mips_decode_execute
// Directed-vector bench with a behavioural instruction-level model of the
// ID/EX and EX/MEM stages, a per-cycle compare process, and literal
// expectations taken from hand-worked examples.
module tb_mips_decode_execute;

  logic        clk, rst_n;
  logic [31:0] instr_d, rdata1_d, rdata2_d;
  logic        stall, flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] fwd_mem, fwd_wb;
  logic [4:0]  rs_e, rt_e, wrreg_m;
  logic        memread_e, zero_m, regwrite_m, memtoreg_m, memread_m;
  logic        memwrite_m, jump_m, pcsrc_m;
  logic [31:0] alu_result_m, store_data_m;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'hFC00_0000;

  mips_decode_execute dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .rdata1_d(rdata1_d),
    .rdata2_d(rdata2_d), .stall(stall), .flush(flush), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .rs_e(rs_e),
    .rt_e(rt_e), .memread_e(memread_e), .alu_result_m(alu_result_m),
    .zero_m(zero_m), .store_data_m(store_data_m), .wrreg_m(wrreg_m),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .memread_m(memread_m),
    .memwrite_m(memwrite_m), .jump_m(jump_m), .pcsrc_m(pcsrc_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic [31:0] store;
    logic [4:0]  wrreg;
    logic        rw, mtr, mr, mw, j, beq, bne;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r,
                                       input logic [31:0] m, input logic [31:0] w);
    case (s)
      2'd1:    return m;
      2'd2:    return w;
      default: return r;
    endcase
  endfunction

  // What one instruction in EX produces, stated per instruction kind
  function automatic exp_t model_ex(input logic [31:0] ins, input logic live,
                                    input logic [31:0] r1, input logic [31:0] r2,
                                    input logic [1:0] fa, input logic [1:0] fb,
                                    input logic [31:0] fm, input logic [31:0] fw);
    exp_t e;
    logic [31:0] a, t, imm;
    logic [5:0]  op;
    e     = '0;
    a     = pick(fa, r1, fm, fw);
    t     = pick(fb, r2, fm, fw);
    imm   = {{16{ins[15]}}, ins[15:0]};
    op    = live ? ins[31:26] : 6'h3F;
    e.store = t;
    e.wrreg = ins[20:16];
    e.res   = a + t;
    case (op)
      6'h00: begin
        e.wrreg = ins[15:11];
        e.rw    = 1'b1;
        case (ins[5:0])
          6'h22:   e.res = a - t;
          6'h24:   e.res = a & t;
          6'h25:   e.res = a | t;
          6'h2A:   e.res = ($signed(a) < $signed(t)) ? 32'd1 : 32'd0;
          6'h27:   e.res = ~(a | t);
          default: e.res = a + t;
        endcase
      end
      6'h23: begin e.res = a + imm; e.mr = 1'b1; e.mtr = 1'b1; e.rw = 1'b1; end
      6'h2B: begin e.res = a + imm; e.mw = 1'b1; end
      6'h04: begin e.res = a - t; e.beq = 1'b1; end
      6'h05: begin e.res = a - t; e.bne = 1'b1; end
      6'h08: begin e.res = a + imm; e.rw = 1'b1; end
      6'h02: e.j = 1'b1;
      default: e.res = a + t;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Model pipeline state: instruction in EX and its outcome in MEM
  logic [31:0] m_instr, m_r1, m_r2;
  logic        m_live, m_known, m_ex_known;
  exp_t        m_ex;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_instr <= 32'd0; m_r1 <= 32'd0; m_r2 <= 32'd0;
      m_live <= 1'b0; m_known <= 1'b1; m_ex <= '0; m_ex_known <= 1'b1;
    end else begin
      if (flush) begin
        m_ex       <= '0;
        m_ex_known <= 1'b0;
      end else begin
        m_ex       <= model_ex(m_instr, m_live, m_r1, m_r2, fwd_a, fwd_b, fwd_mem, fwd_wb);
        m_ex_known <= m_known;
      end
      m_instr <= instr_d;
      m_r1    <= rdata1_d;
      m_r2    <= rdata2_d;
      m_live  <= !(stall || flush);
      m_known <= !flush;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_known) begin
      chk("rs_e", {27'd0, rs_e}, {27'd0, m_instr[25:21]});
      chk("rt_e", {27'd0, rt_e}, {27'd0, m_instr[20:16]});
    end
    chk("memread_e", {31'd0, memread_e}, {31'd0, (m_live && m_instr[31:26] == 6'h23)});
    if (m_ex_known) begin
      chk("alu_result_m", alu_result_m, m_ex.res);
      chk("zero_m", {31'd0, zero_m}, {31'd0, m_ex.zero});
      chk("store_data_m", store_data_m, m_ex.store);
      chk("wrreg_m", {27'd0, wrreg_m}, {27'd0, m_ex.wrreg});
    end
    chk("regwrite_m", {31'd0, regwrite_m}, {31'd0, m_ex.rw});
    chk("memtoreg_m", {31'd0, memtoreg_m}, {31'd0, m_ex.mtr});
    chk("memread_m",  {31'd0, memread_m},  {31'd0, m_ex.mr});
    chk("memwrite_m", {31'd0, memwrite_m}, {31'd0, m_ex.mw});
    chk("jump_m",     {31'd0, jump_m},     {31'd0, m_ex.j});
    chk("pcsrc_m", {31'd0, pcsrc_m},
        {31'd0, (m_ex.beq & m_ex.zero) | (m_ex.bne & ~m_ex.zero)});
  end

  task automatic step(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic [31:0] fm, input logic [31:0] fw,
                      input logic st, input logic fl);
    instr_d = ins; rdata1_d = r1; rdata2_d = r2;
    fwd_a = fa; fwd_b = fb; fwd_mem = fm; fwd_wb = fw;
    stall = st; flush = fl;
    @(negedge clk);
  endtask

  // Instruction through ID, then its forwarding inputs while it sits in EX
  task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] fm, input logic [31:0] fw);
    step(ins, r1, r2, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(NOP, 32'd0, 32'd0, fa, fb, fm, fw, 1'b0, 1'b0);
  endtask

  logic [31:0] tab_i [10];

  initial begin
    rst_n = 1'b0; instr_d = 32'd0; rdata1_d = 32'd0; rdata2_d = 32'd0;
    stall = 1'b0; flush = 1'b0; fwd_a = 2'd0; fwd_b = 2'd0;
    fwd_mem = 32'd0; fwd_wb = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset alu_result_m", alu_result_m, 32'd0);
    chk("reset regwrite_m", {31'd0, regwrite_m}, 32'd0);
    chk("reset pcsrc_m", {31'd0, pcsrc_m}, 32'd0);
    rst_n = 1'b1;

    // R-type add 5 + 7
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7, 2'd0, 2'd0, 32'd0, 32'd0);
    chk("add result", alu_result_m, 32'd12);
    chk("add wrreg", {27'd0, wrreg_m}, 32'd3);
    chk("add regwrite", {31'd0, regwrite_m}, 32'd1);
    chk("add zero", {31'd0, zero_m}, 32'd0);

    // signed slt both ways, nor
    issue(rtype(5'd1, 5'd2, 5'd4, 6'h2A), 32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0, 32'd0, 32'd0);
    chk("slt -1<1", alu_result_m, 32'd1);
    issue(rtype(5'd1, 5'd2, 5'd4, 6'h2A), 32'd1, 32'hFFFF_FFFF, 2'd0, 2'd0, 32'd0, 32'd0);
    chk("slt 1<-1", alu_result_m, 32'd0);
    issue(rtype(5'd1, 5'd2, 5'd4, 6'h27), 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    chk("nor", alu_result_m, 32'hFFFF_FFFF);

    // branches on equal operands
    issue(itype(6'h04, 5'd1, 5'd2, 16'h0010), 32'd9, 32'd9, 2'd0, 2'd0, 32'd0, 32'd0);
    chk("beq zero", {31'd0, zero_m}, 32'd1);
    chk("beq pcsrc", {31'd0, pcsrc_m}, 32'd1);
    issue(itype(6'h05, 5'd1, 5'd2, 16'h0010), 32'd9, 32'd9, 2'd0, 2'd0, 32'd0, 32'd0);
    chk("bne pcsrc", {31'd0, pcsrc_m}, 32'd0);

    // load / store
    issue(itype(6'h23, 5'd5, 5'd6, 16'hFFFC), 32'h100, 32'h55, 2'd0, 2'd0, 32'd0, 32'd0);
    chk("lw addr", alu_result_m, 32'h0000_00FC);
    chk("lw memread", {31'd0, memread_m}, 32'd1);
    chk("lw memtoreg", {31'd0, memtoreg_m}, 32'd1);
    chk("lw wrreg", {27'd0, wrreg_m}, 32'd6);
    issue(itype(6'h2B, 5'd5, 5'd7, 16'h0008), 32'h200, 32'hDEAD_BEEF, 2'd0, 2'd0, 32'd0, 32'd0);
    chk("sw memwrite", {31'd0, memwrite_m}, 32'd1);
    chk("sw store", store_data_m, 32'hDEAD_BEEF);
    chk("sw addr", alu_result_m, 32'h0000_0208);

    // forwarding
    issue(itype(6'h08, 5'd1, 5'd2, 16'd5), 32'h77, 32'd0, 2'd1, 2'd0, 32'd20, 32'd0);
    chk("fwd mem addi", alu_result_m, 32'd25);
    issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd10, 32'd99, 2'd0, 2'd2, 32'd0, 32'd1000);
    chk("fwd wb add", alu_result_m, 32'd1010);
    chk("fwd wb store", store_data_m, 32'd1000);

    // stall bubbles
    step(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(NOP, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("stall regwrite", {31'd0, regwrite_m}, 32'd0);
    chk("stall data", alu_result_m, 32'd12);
    step(itype(6'h2B, 5'd1, 5'd2, 16'd4), 32'd1, 32'd2, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(NOP, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("stall memwrite", {31'd0, memwrite_m}, 32'd0);

    // flush kills both stages
    step(itype(6'h23, 5'd5, 5'd6, 16'd4), 32'h40, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(itype(6'h2B, 5'd5, 5'd6, 16'd4), 32'h40, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("flush memread_m", {31'd0, memread_m}, 32'd0);
    chk("flush regwrite_m", {31'd0, regwrite_m}, 32'd0);
    chk("flush memread_e", {31'd0, memread_e}, 32'd0);
    step(itype(6'h23, 5'd5, 5'd6, 16'd4), 32'h40, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("flush memwrite_m", {31'd0, memwrite_m}, 32'd0);
    step(NOP, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("stall+flush memread_m", {31'd0, memread_m}, 32'd0);

    // undefined opcode behaves as NOP; jump
    issue(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 32'd3, 32'd4, 2'd0, 2'd0, 32'd0, 32'd0);
    chk("undef regwrite", {31'd0, regwrite_m}, 32'd0);
    chk("undef memwrite", {31'd0, memwrite_m}, 32'd0);
    chk("undef result", alu_result_m, 32'd7);
    issue({6'h02, 26'h000_0010}, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0);
    chk("jump", {31'd0, jump_m}, 32'd1);

    // back-to-back stream with varied forwarding
    tab_i = '{rtype(5'd1, 5'd2, 5'd3, 6'h22), rtype(5'd4, 5'd5, 5'd6, 6'h24),
              rtype(5'd7, 5'd8, 5'd9, 6'h25), rtype(5'd10, 5'd11, 5'd12, 6'h00),
              itype(6'h04, 5'd1, 5'd2, 16'h0004), itype(6'h05, 5'd3, 5'd4, 16'h0008),
              itype(6'h08, 5'd9, 5'd10, 16'h8000), itype(6'h23, 5'd2, 5'd3, 16'h7FFF),
              rtype(5'd13, 5'd14, 5'd15, 6'h2A), itype(6'h2B, 5'd6, 5'd7, 16'hFFF0)};
    for (int i = 0; i < 10; i++) begin
      step(tab_i[i], 32'h1234_0000 + i * 32'h0101, 32'h0000_F0F0 - i, 2'(i % 4), 2'((i + 1) % 4),
           32'h0000_1000 + i, 32'hFFFF_FFF0 ^ i, 1'b0, 1'b0);
    end
    step(NOP, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // asynchronous reset mid-stream
    step(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre-reset result", alu_result_m, 32'd12);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst result", alu_result_m, 32'd0);
    chk("async rst regwrite", {31'd0, regwrite_m}, 32'd0);
    chk("async rst rs_e", {27'd0, rs_e}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(rtype(5'd2, 5'd3, 5'd8, 6'h22), 32'd3, 32'd3, 2'd0, 2'd0, 32'd0, 32'd0);
    chk("post-reset sub zero", {31'd0, zero_m}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
